seven_segment_scanner: RTL and testbench

- Time-multiplexes one shared `seven_segment` decoder across up to 4 common-anode digits on the lab board.
- Holds a writable 4-bit value per digit. Steps a refresh counter and presents one digit's nibble to the decoder, with the matching active-low anode enable.
- Sits between the user datapath (which writes digit values) and the `seven_segment` decoder plus the board anode pins.

---
 rtl/seven_segment_scanner_if.sv | 22 ++
 rtl/seven_segment_scanner.sv | 82 ++++++++
 tb/tb_seven_segment_scanner.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Digit-write and display-output bundle between the user datapath and the scanner.
interface seven_segment_scanner_if;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] digit_out;
    logic [3:0] an;
    logic       frame_done;

    // Datapath side: writes digits and enables the display.
    modport master (
        output en, wr_en, wr_addr, wr_data,
        input  digit_out, an, frame_done
    );

    // Scanner side.
    modport slave (
        input  en, wr_en, wr_addr, wr_data,
        output digit_out, an, frame_done
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for up to four common-anode seven-segment digits.
// Holds one nibble per digit, steps a refresh counter and presents the current
// digit's nibble with its active-low anode enable; leading zeros may be blanked.
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_segment_scanner_if.slave  bus
);

    localparam int unsigned CNT_W     = $clog2(REFRESH_DIV);
    localparam int unsigned ND        = 32'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0] LAST_IDX   = 2'(NUM_DIGITS - 1);
    localparam logic [3:0] LIVE_MASK  = 4'((1 << NUM_DIGITS) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       digit_q [4];
    logic             tick_c;
    logic             zero_run;
    logic [3:0]       blank_c;
    logic [3:0]       an_c;

    assign tick_c = (cnt_q == CNT_MAX);

    // Refresh counter, scan index and digit registers; a write may share an edge with tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
            if (tick_c) begin
                idx_q <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
            end
            if (bus.wr_en && (32'(bus.wr_addr) < ND)) begin
                digit_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Digit i>=1 is blanked when it and every more-significant digit are zero.
    always_comb begin
        blank_c  = '0;
        zero_run = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (i < NUM_DIGITS) begin
                zero_run   = zero_run & (digit_q[i] == 4'h0);
                blank_c[i] = zero_run & (LZ_BLANK != 0);
            end
        end
    end

    // Anode pattern for the current index; unused anode positions stay off.
    always_comb begin
        an_c = 4'hF;
        if (bus.en && !blank_c[idx_q]) begin
            an_c = ~(4'b0001 << idx_q) | ~LIVE_MASK;
        end
    end

    // Registered display outputs, one clk behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.digit_out  <= 4'h0;
            bus.an         <= 4'hF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.digit_out  <= digit_q[idx_q];
            bus.an         <= an_c;
            bus.frame_done <= tick_c && (idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: two scanner configurations share one stimulus stream.
// A time-division reference model predicts every output cycle; a monitor compares.
module tb_seven_segment_scanner;

    typedef struct {
        logic [3:0] d;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    logic clk;
    logic rst;

    seven_segment_scanner_if bus_a ();
    seven_segment_scanner_if bus_b ();

    // A: 4 digits, fast refresh, leading-zero blanking.
    seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    // B: 3 digits, odd refresh, no blanking.
    seven_segment_scanner #(.NUM_DIGITS(3), .REFRESH_DIV(3), .LZ_BLANK(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors = 0;
    int   errors  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs following an edge, from the display rules in time-division form.
    function automatic exp_t predict(int n, int rd, int lz, int k, logic [15:0] val, logic en_i);
        exp_t       p;
        int         idx;
        int         cnt;
        logic [15:0] sh;
        logic       blank;
        idx   = (k / rd) % n;
        cnt   = k % rd;
        sh    = val >> (4 * idx);
        blank = (lz != 0) && (idx >= 1) && (sh == 16'h0);
        p.d   = sh[3:0];
        p.an  = (!en_i || blank) ? 4'hF : ~(4'(1) << idx);
        p.fd  = (cnt == rd - 1) && (idx == n - 1);
        return p;
    endfunction

    task automatic check(input string name, input exp_t e,
                         input logic [3:0] d, input logic [3:0] an, input logic fd);
        vectors++;
        if (d !== e.d || an !== e.an || fd !== e.fd) begin
            errors++;
            $display("FAIL %s @%0t: got digit_out=%h an=%b frame_done=%b, expected digit_out=%h an=%b frame_done=%b",
                     name, $time, d, an, fd, e.d, e.an, e.fd);
        end
    endtask

    // Reference model: consumes inputs at each edge and queues the expected response.
    initial begin : model
        int          k_a, k_b;
        logic [15:0] val_a, val_b;
        k_a = 0; k_b = 0; val_a = '0; val_b = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                k_a = 0; k_b = 0; val_a = '0; val_b = '0;
                q_a.delete();
                q_b.delete();
            end else begin
                q_a.push_back(predict(4, 4, 1, k_a, val_a, bus_a.en));
                q_b.push_back(predict(3, 3, 0, k_b, val_b, bus_b.en));
                if (bus_a.wr_en && int'(bus_a.wr_addr) < 4)
                    val_a[4*bus_a.wr_addr +: 4] = bus_a.wr_data;
                if (bus_b.wr_en && int'(bus_b.wr_addr) < 3)
                    val_b[4*bus_b.wr_addr +: 4] = bus_b.wr_data;
                k_a++;
                k_b++;
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin : monitor
        exp_t rst_exp;
        exp_t e;
        rst_exp.d  = 4'h0;
        rst_exp.an = 4'hF;
        rst_exp.fd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_a", rst_exp, bus_a.digit_out, bus_a.an, bus_a.frame_done);
                check("reset_b", rst_exp, bus_b.digit_out, bus_b.an, bus_b.frame_done);
            end else begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("scan_a", e, bus_a.digit_out, bus_a.an, bus_a.frame_done);
                end
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    check("scan_b", e, bus_b.digit_out, bus_b.an, bus_b.frame_done);
                end
            end
        end
    end

    // Advance to just after the next falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_en(input logic v);
        bus_a.en = v;
        bus_b.en = v;
    endtask

    task automatic set_wr(input logic we, input logic [1:0] addr, input logic [3:0] data);
        bus_a.wr_en   = we;
        bus_a.wr_addr = addr;
        bus_a.wr_data = data;
        bus_b.wr_en   = we;
        bus_b.wr_addr = addr;
        bus_b.wr_data = data;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [3:0] data);
        set_wr(1'b1, addr, data);
        step(1);
        set_wr(1'b0, 2'd0, 4'h0);
    endtask

    // Stimulus.
    initial begin : stim
        exp_t rst_exp;
        rst_exp.d  = 4'h0;
        rst_exp.an = 4'hF;
        rst_exp.fd = 1'b0;

        rst = 1'b1;
        set_en(1'b1);
        set_wr(1'b0, 2'd0, 4'h0);
        step(3);
        rst = 1'b0;

        // All zeros: only digit 0 lit on A.
        step(16);

        // Full scan with digits 3..0 = 1,2,3,4.
        wr(2'd3, 4'h1);
        wr(2'd2, 4'h2);
        wr(2'd1, 4'h3);
        wr(2'd0, 4'h4);
        step(20);

        // Leading-zero pattern 0,0,5,0.
        wr(2'd3, 4'h0);
        wr(2'd2, 4'h0);
        wr(2'd1, 4'h5);
        wr(2'd0, 4'h0);
        step(16);

        // Writes landing on the lit digit, plus address 3 (ignored by B).
        for (int i = 0; i < 8; i++) begin
            wr(2'(i % 4), 4'h9);
            step(1);
        end
        wr(2'd3, 4'hA);
        step(12);

        // Enable dropped for a while, scan keeps running.
        set_en(1'b0);
        step(10);
        set_en(1'b1);
        step(10);

        // Randomized writes and enable toggles, biased toward zeros for blanking.
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_wr(1'b1, 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
            else
                set_wr(1'b0, 2'd0, 4'h0);
            if ($urandom_range(0, 15) == 0)
                set_en(~bus_a.en);
            step(1);
        end
        set_wr(1'b0, 2'd0, 4'h0);
        set_en(1'b1);
        step(5);

        // Reset mid-digit: outputs must clear before any clock edge.
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_a", rst_exp, bus_a.digit_out, bus_a.an, bus_a.frame_done);
        check("async_reset_b", rst_exp, bus_b.digit_out, bus_b.an, bus_b.frame_done);
        step(2);
        rst = 1'b0;

        // After reset every digit reads back 0 and scanning restarts at digit 0.
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
